// File: rtl/mul_pkg.sv
// Shared constants and sideband type for the pipelined 18x18 multiplier and its consumers.
package mul_pkg;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned PW      = 36;
    localparam int unsigned OPW     = 18;

    typedef struct packed {
        logic valid;
        logic last;
    } side_t;

endpackage

// File: rtl/mul_accum_if.sv
// Input sideband/product and result handshake bundle for mul_accum.
interface mul_accum_if #(
    parameter int unsigned PW    = mul_pkg::PW,
    parameter int unsigned AW    = 48,
    parameter int unsigned CNT_W = 16
);

    logic             in_valid;
    logic             in_last;
    logic [PW-1:0]    mul;
    logic             acc_ready;
    logic             acc_valid;
    logic [AW-1:0]    acc_out;
    logic [CNT_W-1:0] acc_count;
    logic             acc_ovf;

    modport slave (
        input  in_valid, in_last, mul, acc_ready,
        output acc_valid, acc_out, acc_count, acc_ovf
    );

    modport master (
        output in_valid, in_last, mul, acc_ready,
        input  acc_valid, acc_out, acc_count, acc_ovf
    );

endinterface

// File: rtl/valid_delay.sv
// Fixed-depth shift register for sideband bits, cleared by asynchronous active-low reset.
module valid_delay #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/mul_accum.sv
// Frame accumulator behind the pipelined multiplier, with a 1-deep valid/ready result register.
// Define MUL_ACCUM_SAT_EN to saturate the accumulator on carry instead of wrapping.
module mul_accum
    import mul_pkg::*;
#(
    parameter int unsigned MUL_LAT = mul_pkg::MUL_LAT,
    parameter int unsigned PW      = mul_pkg::PW,
    parameter int unsigned AW      = 48,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_accum_if.slave bus,
    output logic       drop
);

    side_t side_in, side_d;

    assign side_in.valid = bus.in_valid;
    assign side_in.last  = bus.in_last & bus.in_valid;

    valid_delay #(
        .DEPTH(MUL_LAT),
        .WIDTH($bits(side_t))
    ) u_valid_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (side_in),
        .q    (side_d)
    );

    logic [AW-1:0]    acc_q, acc_base, acc_d;
    logic [AW:0]      sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, first_q;
    logic             frame_end;

    logic             res_valid_q, drop_q, res_ovf_q;
    logic [AW-1:0]    res_out_q;
    logic [CNT_W-1:0] res_cnt_q;

    assign frame_end = side_d.valid & side_d.last;

    // The first product of a frame starts from zero rather than the stale total.
    always_comb begin
        acc_base = first_q ? '0 : acc_q;
        sum      = {1'b0, acc_base} + {{(AW + 1 - PW){1'b0}}, bus.mul};
        cnt_d    = (first_q ? '0 : cnt_q) + CNT_W'(1);
        ovf_d    = (first_q ? 1'b0 : ovf_q) | sum[AW];
`ifdef MUL_ACCUM_SAT_EN
        // Once at all-ones any non-zero product carries again, so saturation holds.
        acc_d    = sum[AW] ? '1 : sum[AW-1:0];
`else
        acc_d    = sum[AW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
        end else if (side_d.valid) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            first_q <= side_d.last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_cnt_q   <= '0;
            res_ovf_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= frame_end & res_valid_q & ~bus.acc_ready;
            if (frame_end) begin
                if (!res_valid_q || bus.acc_ready) begin
                    res_valid_q <= 1'b1;
                    res_out_q   <= acc_d;
                    res_cnt_q   <= cnt_d;
                    res_ovf_q   <= ovf_d;
                end
            end else if (res_valid_q && bus.acc_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.acc_valid = res_valid_q;
    assign bus.acc_out   = res_out_q;
    assign bus.acc_count = res_cnt_q;
    assign bus.acc_ovf   = res_ovf_q;
    assign drop          = drop_q;

endmodule
